sysbus_arbiter: RTL and testbench
=================================

Name: sysbus_arbiter

Overview:
- Shares the single Sysbus master port between two requesters: requester 0 is instruction fetch and requester 1 is the data/load-store unit.
- Grants one read transaction at a time using round-robin priority.
- Forwards request/ack on the bus side and steers the BEATS-beat response burst back to the owning requester.
- Sits between the core's fetch/memory stages and the Sysbus interface; the core sees a private request/response channel per requester.

Parameters:
- ADDR_W, 64, request address width
- DATA_W, 64, response beat width
- TAG_W, 13, Sysbus reqtag width; forwarded unmodified
- BEATS, 8, response beats per transaction (one 64-byte line)

Ports:
- clk  in  1  clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low reset
- rq_cyc0 / rq_cyc1  in  1  requester wants a transaction; held with addr/tag stable until its rq_ack
- rq_addr0 / rq_addr1  in  ADDR_W  request address
- rq_tag0 / rq_tag1  in  TAG_W  request tag
- rq_ack0 / rq_ack1  out  1  request accepted by bus (one-cycle pulse)
- rs_cyc0 / rs_cyc1  out  1  response beat valid to requester
- rs_data0 / rs_data1  out  DATA_W  response beat
- rs_ack0 / rs_ack1  in  1  requester accepts beat
- bus_reqcyc  out  1  Sysbus request valid
- bus_req  out  ADDR_W  Sysbus request address
- bus_reqtag  out  TAG_W  Sysbus request tag
- bus_reqack  in  1  Sysbus request accepted
- bus_respcyc  in  1  Sysbus response beat valid
- bus_resp  in  DATA_W  Sysbus response beat
- bus_respack  out  1  response beat accepted
- owner  out  1  current/last granted requester index
- err  out  1  sticky: response beat received with no transaction outstanding

Behaviour:
- Reset: while reset is low, all outputs are 0, state=IDLE, beat count=0, priority pointer=0 (requester 0 wins first tie); err is cleared.
- IDLE:
  - Sample rq_cyc0/1. If exactly one is high, grant it. If both are high, grant the requester not equal to last_grant.
  - On grant: register bus_req/bus_reqtag from the granted requester, set bus_reqcyc=1 and owner=grant, then go to REQ.
  - bus_reqcyc rises one cycle after rq_cyc is sampled.
- REQ:
  - Hold bus_reqcyc/req/reqtag constant until bus_reqack.
  - In the bus_reqack cycle, rq_ack[owner]=1 (combinational from bus_reqack). Next cycle bus_reqcyc=0 and state=RESP.
  - No timeout: a stalled bus holds REQ indefinitely.
- RESP:
  - rs_cyc[owner]=bus_respcyc and rs_data[owner]=bus_resp (combinational). bus_respack=rs_ack[owner]. The non-owner's rs_cyc=0.
  - A beat counts only when bus_respcyc && bus_respack. Cycles with bus_respcyc=1 and rs_ack=0 are stalls and do not count.
  - Beat count is a $clog2(BEATS)+1-bit counter. When it reaches BEATS (counted beat with count==BEATS-1), next state=IDLE, count<=0, last_grant<=owner.
- Turnaround: last beat accepted in cycle N → IDLE at N+1 → next bus_reqcyc at N+2. No overlap of the next request with the current response.
- Stray response: bus_respcyc=1 in IDLE or REQ → bus_respack=1 (drain), no rs_cyc to either requester, err<=1 (sticky until reset).
- A requester dropping rq_cyc after being granted but before rq_ack is a protocol violation. The arbiter ignores it and completes the transaction.
- A requester raising rq_cyc while the other owns the bus waits. It is granted at the next IDLE, so neither requester is starved by a continuously requesting peer.
- Reset asserted mid-transaction (any state) aborts immediately. Any remaining beats after reset release are treated as stray (err=1, drained).

Test Plan:
- Single fetch: rq_cyc0=1, rq_addr0=0x1000, tag0=0x100. Expect bus_reqcyc=1 with bus_req=0x1000 one cycle later. bus_reqack → rq_ack0 pulse. 8 beats 0xA0..0xA7 appear on rs_data0 in order, rs_cyc1 stays 0. owner=0, back to IDLE after beat 8.
- Simultaneous requests from reset: rq_cyc0=rq_cyc1=1, addr0=0x2000, addr1=0x3000. Expect grant 0x2000 first, 8 beats to requester 0, then 0x3000 with bus_reqcyc exactly 2 cycles after the last beat. Then requester 0 again if still requesting (alternation over 4 transactions: 0,1,0,1).
- Response stall: during RESP hold rs_ack1=0 for 3 cycles at beat 4 with bus_respcyc=1. bus_respack stays 0 and the count stays 4. Transaction completes after exactly 8 acked beats.
- Delayed ack: bus_reqack withheld 5 cycles. bus_req/reqtag stay constant and rq_ack1 pulses only in the ack cycle.
- Stray beat: bus_respcyc=1 in IDLE with no request. Expect bus_respack=1, rs_cyc0=rs_cyc1=0, err=1 persisting until reset.
- Reset mid-burst: assert reset after beat 3. Expect all outputs 0 asynchronously (before next clk edge). After release, the first grant goes to requester 0 and leftover beats set err.

Source files
------------

// File: rtl/sysbus_arbiter.sv
// Two-requester round-robin arbiter for the single Sysbus read master port.
// One transaction at a time: request handshake, then a BEATS-beat burst steered to the owner.
module sysbus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int TAG_W  = 13,
    parameter int BEATS  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rq_cyc0,
    input  logic              rq_cyc1,
    input  logic [ADDR_W-1:0] rq_addr0,
    input  logic [ADDR_W-1:0] rq_addr1,
    input  logic [TAG_W-1:0]  rq_tag0,
    input  logic [TAG_W-1:0]  rq_tag1,
    output logic              rq_ack0,
    output logic              rq_ack1,
    output logic              rs_cyc0,
    output logic              rs_cyc1,
    output logic [DATA_W-1:0] rs_data0,
    output logic [DATA_W-1:0] rs_data1,
    input  logic              rs_ack0,
    input  logic              rs_ack1,
    output logic              bus_reqcyc,
    output logic [ADDR_W-1:0] bus_req,
    output logic [TAG_W-1:0]  bus_reqtag,
    input  logic              bus_reqack,
    input  logic              bus_respcyc,
    input  logic [DATA_W-1:0] bus_resp,
    output logic              bus_respack,
    output logic              owner,
    output logic              err
);

    localparam int CNT_W = $clog2(BEATS) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               prio_q, prio_d;
    logic               reqcyc_q, reqcyc_d;
    logic               err_q, err_d;
    logic [ADDR_W-1:0]  req_q, req_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [1:0]         rq_cyc_v;
    logic [1:0]         rs_ack_v;
    logic [1:0]         rq_ack_v;
    logic [1:0]         rs_cyc_v;
    logic [DATA_W-1:0]  rs_data_v [2];
    logic               grant;
    logic               stray;
    logic               beat;

    assign rq_cyc_v = {rq_cyc1, rq_cyc0};
    assign rs_ack_v = {rs_ack1, rs_ack0};

    // prio_q names the requester that wins a tie; it flips away from each finished owner.
    assign grant = (rq_cyc0 && rq_cyc1) ? prio_q : rq_cyc1;
    assign stray = bus_respcyc && (state_q != RESP);
    assign beat  = (state_q == RESP) && bus_respcyc && rs_ack_v[owner_q];

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        prio_d   = prio_q;
        reqcyc_d = reqcyc_q;
        err_d    = err_q;
        req_d    = req_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;

        if (stray) begin
            err_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (|rq_cyc_v) begin
                    owner_d  = grant;
                    req_d    = grant ? rq_addr1 : rq_addr0;
                    tag_d    = grant ? rq_tag1 : rq_tag0;
                    reqcyc_d = 1'b1;
                    state_d  = REQ;
                end
            end
            REQ: begin
                if (bus_reqack) begin
                    reqcyc_d = 1'b0;
                    state_d  = RESP;
                end
            end
            RESP: begin
                if (beat) begin
                    if (cnt_q == CNT_W'(BEATS - 1)) begin
                        cnt_d   = '0;
                        prio_d  = ~owner_q;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            owner_q  <= 1'b0;
            prio_q   <= 1'b0;
            reqcyc_q <= 1'b0;
            err_q    <= 1'b0;
            req_q    <= '0;
            tag_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            prio_q   <= prio_d;
            reqcyc_q <= reqcyc_d;
            err_q    <= err_d;
            req_q    <= req_d;
            tag_q    <= tag_d;
            cnt_q    <= cnt_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_port
            logic sel;
            assign sel            = (owner_q == 1'(gi));
            assign rq_ack_v[gi]   = (state_q == REQ) && bus_reqack && sel;
            assign rs_cyc_v[gi]   = (state_q == RESP) && bus_respcyc && sel;
            assign rs_data_v[gi]  = ((state_q == RESP) && sel) ? bus_resp : '0;
        end
    endgenerate

    assign rq_ack0  = rq_ack_v[0];
    assign rq_ack1  = rq_ack_v[1];
    assign rs_cyc0  = rs_cyc_v[0];
    assign rs_cyc1  = rs_cyc_v[1];
    assign rs_data0 = rs_data_v[0];
    assign rs_data1 = rs_data_v[1];

    // Stray beats are drained; the reset term keeps the drain path quiet while reset is held.
    assign bus_respack = reset && (stray || ((state_q == RESP) && rs_ack_v[owner_q]));

    assign bus_reqcyc = reqcyc_q;
    assign bus_req    = req_q;
    assign bus_reqtag = tag_q;
    assign owner      = owner_q;
    assign err        = err_q;

endmodule

// File: tb/tb_sysbus_arbiter.sv
// Bench for sysbus_arbiter: directed vector table, reset/stray sequences, then a
// randomized run checked against a transaction-level reference model.
module tb_sysbus_arbiter;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          rq_cyc0, rq_cyc1;
    logic [AW-1:0] rq_addr0, rq_addr1;
    logic [TW-1:0] rq_tag0, rq_tag1;
    logic          rq_ack0, rq_ack1;
    logic          rs_cyc0, rs_cyc1;
    logic [DW-1:0] rs_data0, rs_data1;
    logic          rs_ack0, rs_ack1;
    logic          bus_reqcyc;
    logic [AW-1:0] bus_req;
    logic [TW-1:0] bus_reqtag;
    logic          bus_reqack;
    logic          bus_respcyc;
    logic [DW-1:0] bus_resp;
    logic          bus_respack;
    logic          owner;
    logic          err;

    always #5 clk = ~clk;

    sysbus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TAG_W(TW), .BEATS(NB)) dut (
        .clk(clk), .reset(reset),
        .rq_cyc0(rq_cyc0), .rq_cyc1(rq_cyc1),
        .rq_addr0(rq_addr0), .rq_addr1(rq_addr1),
        .rq_tag0(rq_tag0), .rq_tag1(rq_tag1),
        .rq_ack0(rq_ack0), .rq_ack1(rq_ack1),
        .rs_cyc0(rs_cyc0), .rs_cyc1(rs_cyc1),
        .rs_data0(rs_data0), .rs_data1(rs_data1),
        .rs_ack0(rs_ack0), .rs_ack1(rs_ack1),
        .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_reqack(bus_reqack), .bus_respcyc(bus_respcyc), .bus_resp(bus_resp),
        .bus_respack(bus_respack), .owner(owner), .err(err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic drive_zero();
        rq_cyc0 = 0; rq_cyc1 = 0; bus_reqack = 0; bus_respcyc = 0;
        bus_resp = '0; rs_ack0 = 0; rs_ack1 = 0;
    endtask

    typedef struct {
        logic        c0, c1, rack, rcyc, a0, a1;
        logic [63:0] rdata;
        logic        e_reqcyc, e_ack0, e_ack1, e_rs0, e_rs1, e_respack, e_owner, e_err;
    } vec_t;

    function automatic vec_t mk(input logic c0, c1, rack, rcyc, a0, a1, input logic [63:0] rdata,
                                input logic e_reqcyc, e_ack0, e_ack1, e_rs0, e_rs1,
                                input logic e_respack, e_owner, e_err);
        vec_t v;
        v.c0 = c0; v.c1 = c1; v.rack = rack; v.rcyc = rcyc; v.a0 = a0; v.a1 = a1; v.rdata = rdata;
        v.e_reqcyc = e_reqcyc; v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_rs0 = e_rs0;
        v.e_rs1 = e_rs1; v.e_respack = e_respack; v.e_owner = e_owner; v.e_err = e_err;
        return v;
    endfunction

    localparam logic [63:0] A0 = 64'h1000;
    localparam logic [63:0] A1 = 64'h3000;
    localparam logic [12:0] T0 = 13'h100;
    localparam logic [12:0] T1 = 13'h101;

    // Reference model state for the randomized run (transaction view, not cycle-state).
    logic          want [2];
    logic [63:0]   raddr [2];
    logic [12:0]   rtag [2];

    initial begin
        vec_t vecs[$];

        drive_zero();
        rq_addr0 = A0; rq_addr1 = A1; rq_tag0 = T0; rq_tag1 = T1;

        // Reset state, with a beat offered to show the drain path is quiet in reset.
        bus_respcyc = 1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_reqcyc", 64'(bus_reqcyc), 0);
        chk("rst_respack", 64'(bus_respack), 0);
        chk("rst_owner", 64'(owner), 0);
        chk("rst_err", 64'(err), 0);
        chk("rst_rscyc", 64'({rs_cyc0, rs_cyc1, rq_ack0, rq_ack1}), 0);
        @(negedge clk);
        drive_zero();
        reset = 1;

        // Single fetch from requester 0: request sampled, reqcyc next cycle, ack, 8 beats.
        vecs.push_back(mk(1,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,0,0,0,0, 1,0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0,0,0,0, 1,1,0,0,0,0,0,0));
        for (int b = 0; b < NB; b++)
            vecs.push_back(mk(0,0,0,1,1,0,64'hA0 + 64'(b), 0,0,0,1,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,0));
        // Stray beat in IDLE: drained, no rs_cyc, err sets on the next edge and sticks.
        vecs.push_back(mk(0,0,0,1,0,0,64'hDEAD, 0,0,0,0,0,1,0,0));
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,0,1));
        // Requester 1 with a 5-cycle delayed ack, then a 3-cycle stall at beat 4.
        vecs.push_back(mk(0,1,0,0,0,0,0, 0,0,0,0,0,0,0,1));
        for (int k = 0; k < 5; k++)
            vecs.push_back(mk(0,1,0,0,0,0,0, 1,0,0,0,0,0,1,1));
        vecs.push_back(mk(0,1,1,0,0,0,0, 1,0,1,0,0,0,1,1));
        for (int b = 0; b < NB; b++) begin
            if (b == 4)
                for (int s = 0; s < 3; s++)
                    vecs.push_back(mk(0,0,0,1,1,0,64'hB4, 0,0,0,0,1,0,1,1));
            vecs.push_back(mk(0,0,0,1,0,1,64'hB0 + 64'(b), 0,0,0,0,1,1,1,1));
        end
        vecs.push_back(mk(0,0,0,0,0,0,0, 0,0,0,0,0,0,1,1));

        foreach (vecs[i]) begin
            @(negedge clk);
            rq_cyc0 = vecs[i].c0; rq_cyc1 = vecs[i].c1; bus_reqack = vecs[i].rack;
            bus_respcyc = vecs[i].rcyc; rs_ack0 = vecs[i].a0; rs_ack1 = vecs[i].a1;
            bus_resp = vecs[i].rdata;
            #1;
            chk($sformatf("v%0d_reqcyc", i), 64'(bus_reqcyc), 64'(vecs[i].e_reqcyc));
            if (vecs[i].e_reqcyc) begin
                chk($sformatf("v%0d_req", i), bus_req, vecs[i].e_owner ? A1 : A0);
                chk($sformatf("v%0d_tag", i), 64'(bus_reqtag), 64'(vecs[i].e_owner ? T1 : T0));
            end
            chk($sformatf("v%0d_ack", i), 64'({rq_ack0, rq_ack1}), 64'({vecs[i].e_ack0, vecs[i].e_ack1}));
            chk($sformatf("v%0d_rscyc", i), 64'({rs_cyc0, rs_cyc1}), 64'({vecs[i].e_rs0, vecs[i].e_rs1}));
            if (vecs[i].e_rs0) chk($sformatf("v%0d_data0", i), rs_data0, vecs[i].rdata);
            if (vecs[i].e_rs1) chk($sformatf("v%0d_data1", i), rs_data1, vecs[i].rdata);
            chk($sformatf("v%0d_respack", i), 64'(bus_respack), 64'(vecs[i].e_respack));
            chk($sformatf("v%0d_owner", i), 64'(owner), 64'(vecs[i].e_owner));
            chk($sformatf("v%0d_err", i), 64'(err), 64'(vecs[i].e_err));
        end

        // Reset in the middle of a requester-1 burst, after beat 3.
        @(negedge clk); drive_zero(); rq_cyc1 = 1;
        @(negedge clk); bus_reqack = 1;
        for (int b = 0; b < 3; b++) begin
            @(negedge clk);
            drive_zero(); bus_respcyc = 1; rs_ack1 = 1; bus_resp = 64'hC0 + 64'(b);
        end
        @(negedge clk);
        #1;
        chk("mid_owner_before", 64'(owner), 1);
        chk("mid_rscyc_before", 64'(rs_cyc1), 1);
        reset = 0;
        #1;
        chk("mid_async_rscyc", 64'({rs_cyc0, rs_cyc1}), 0);
        chk("mid_async_respack", 64'(bus_respack), 0);
        chk("mid_async_owner", 64'(owner), 0);
        chk("mid_async_err", 64'(err), 0);
        chk("mid_async_reqcyc", 64'(bus_reqcyc), 0);
        @(negedge clk);
        reset = 1; rq_cyc0 = 1; rq_cyc1 = 1;
        #1;
        chk("left_respack", 64'(bus_respack), 1);
        chk("left_rscyc", 64'({rs_cyc0, rs_cyc1}), 0);
        @(negedge clk);
        #1;
        chk("left_reqcyc", 64'(bus_reqcyc), 1);
        chk("left_req", bus_req, A0);
        chk("left_owner", 64'(owner), 0);
        chk("left_err", 64'(err), 1);
        @(negedge clk); drive_zero(); reset = 0;
        @(negedge clk); reset = 1;

        // Randomized run against the transaction-level model.
        begin
            int          beats_left = 0;
            bit          awaiting = 0;
            int          mown = 0;
            int          mprio = 0;
            int          ntx = 0;
            logic [63:0] maddr = '0;
            logic [12:0] mtag = '0;
            bit          in_resp, own_ack;

            want[0] = 0; want[1] = 0;
            for (int cyc = 0; cyc < 4000; cyc++) begin
                @(negedge clk);
                for (int r = 0; r < 2; r++) begin
                    if (!want[r] && $urandom_range(3) == 0) begin
                        want[r]  = 1;
                        raddr[r] = {$urandom, $urandom};
                        rtag[r]  = 13'($urandom);
                    end
                end
                rq_cyc0 = want[0]; rq_cyc1 = want[1];
                rq_addr0 = raddr[0]; rq_addr1 = raddr[1];
                rq_tag0 = rtag[0]; rq_tag1 = rtag[1];
                in_resp = !awaiting && beats_left > 0;
                bus_reqack  = awaiting && ($urandom_range(2) == 0);
                bus_respcyc = in_resp && ($urandom_range(9) < 7);
                bus_resp    = {$urandom, $urandom};
                rs_ack0     = ($urandom_range(9) < 7);
                rs_ack1     = ($urandom_range(9) < 7);
                own_ack     = (mown == 1) ? rs_ack1 : rs_ack0;
                #1;
                chk("rnd_reqcyc", 64'(bus_reqcyc), 64'(awaiting));
                if (awaiting) begin
                    chk("rnd_req", bus_req, maddr);
                    chk("rnd_tag", 64'(bus_reqtag), 64'(mtag));
                end
                chk("rnd_ack0", 64'(rq_ack0), 64'(awaiting && bus_reqack && mown == 0));
                chk("rnd_ack1", 64'(rq_ack1), 64'(awaiting && bus_reqack && mown == 1));
                chk("rnd_rs0", 64'(rs_cyc0), 64'(bus_respcyc && mown == 0));
                chk("rnd_rs1", 64'(rs_cyc1), 64'(bus_respcyc && mown == 1));
                if (bus_respcyc) chk("rnd_data", (mown == 1) ? rs_data1 : rs_data0, bus_resp);
                chk("rnd_respack", 64'(bus_respack), 64'(in_resp && own_ack));
                chk("rnd_owner", 64'(owner), 64'(mown));
                chk("rnd_err", 64'(err), 0);

                if (awaiting) begin
                    if (bus_reqack) begin
                        awaiting   = 0;
                        beats_left = NB;
                        want[mown] = 0;
                    end
                end else if (beats_left > 0) begin
                    if (bus_respcyc && own_ack) begin
                        beats_left--;
                        if (beats_left == 0) begin
                            ntx++;
                            mprio = 1 - mown;
                            $display("txn %0d requester %0d addr %h tag %h done", ntx, mown, maddr, mtag);
                        end
                    end
                end else if (want[0] || want[1]) begin
                    mown     = (want[0] && want[1]) ? mprio : (want[1] ? 1 : 0);
                    maddr    = raddr[mown];
                    mtag     = rtag[mown];
                    awaiting = 1;
                end
            end
            chk("rnd_progress", 64'(ntx > 50), 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
